// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N stream demux with one valid/ready slot per output channel.
// Define DEMUX_CNT_EN to add per-channel delivered-beat counters on port ch_count.

module stream_demux_slot #(
  parameter int DATA_W = 2
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] count
`endif
);

  // Fill wins over drain so a drain+fill cycle keeps the slot full with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= fill_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (valid && ready) count <= count + 1'b1;
  end
`endif

endmodule

module stream_demux_n #(
  parameter  int DATA_W = 2,
  parameter  int N_CH   = 2,
  parameter  int CNT_W  = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic                   err_sel
`ifdef DEMUX_CNT_EN
  , output logic [N_CH*CNT_W-1:0] ch_count
`endif
);

  logic [N_CH-1:0]             hit, busy, fill;
  logic [N_CH-1:0][DATA_W-1:0] slot_data;
  logic                        accept, sel_ok;

`ifdef DEMUX_CNT_EN
  logic [N_CH-1:0][CNT_W-1:0] slot_cnt;
  assign ch_count = slot_cnt;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

  // Per-channel decode keeps out-of-range selects from indexing past the slot array.
  assign sel_ok   = |hit;
  assign in_ready = !reset && !(|(hit & busy));
  assign accept   = in_valid && in_ready;
  assign fill     = hit & {N_CH{accept}};
  assign out_data = slot_data;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign hit[k]  = (in_sel == SEL_W'(k));
    assign busy[k] = out_valid[k] && !out_ready[k];

    stream_demux_slot #(
      .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
      , .CNT_W (CNT_W)
`endif
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .fill      (fill[k]),
      .fill_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (slot_data[k])
`ifdef DEMUX_CNT_EN
      , .count   (slot_cnt[k])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (reset) err_sel <= 1'b0;
    else       err_sel <= accept && !sel_ok;
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboard bench for stream_demux_n: a 2-channel/2-bit and a 3-channel/8-bit instance share clk and reset.
// Driver pushes expected beats per channel; a negedge monitor pops and compares on every delivery.

module tb_stream_demux_n;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  d2_in_data;
  logic [0:0]  d2_in_sel;
  logic        d2_in_valid, d2_in_ready, d2_err;
  logic [3:0]  d2_out_data;
  logic [1:0]  d2_out_valid, d2_out_ready;

  logic [7:0]  d3_in_data;
  logic [1:0]  d3_in_sel;
  logic        d3_in_valid, d3_in_ready, d3_err;
  logic [23:0] d3_out_data;
  logic [2:0]  d3_out_valid, d3_out_ready;

`ifdef DEMUX_CNT_EN
  logic [3:0]  d2_cnt;
  logic [5:0]  d3_cnt;
`endif

  stream_demux_n #(.DATA_W(2), .N_CH(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_data(d2_in_data), .in_sel(d2_in_sel),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .out_data(d2_out_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .err_sel(d2_err)
`ifdef DEMUX_CNT_EN
    , .ch_count(d2_cnt)
`endif
  );

  stream_demux_n #(.DATA_W(8), .N_CH(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(d3_in_data), .in_sel(d3_in_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .err_sel(d3_err)
`ifdef DEMUX_CNT_EN
    , .ch_count(d3_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [1:0] q2 [2][$];
  logic [7:0] q3 [3][$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    for (int k = 0; k < 2; k++) q2[k].delete();
    for (int k = 0; k < 3; k++) q3[k].delete();
  endtask

  // Monitor: every delivered beat must match the oldest expectation of its channel.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++)
        if (d2_out_valid[k] && d2_out_ready[k]) begin
          if (q2[k].size() == 0) check($sformatf("sb2_extra_ch%0d", k), 1, 0);
          else begin
            logic [1:0] e2;
            e2 = q2[k].pop_front();
            check($sformatf("sb2_data_ch%0d", k), 32'(d2_out_data[k*2 +: 2]), 32'(e2));
          end
        end
      for (int k = 0; k < 3; k++)
        if (d3_out_valid[k] && d3_out_ready[k]) begin
          if (q3[k].size() == 0) check($sformatf("sb3_extra_ch%0d", k), 1, 0);
          else begin
            logic [7:0] e3;
            e3 = q3[k].pop_front();
            check($sformatf("sb3_data_ch%0d", k), 32'(d3_out_data[k*8 +: 8]), 32'(e3));
          end
        end
    end
  end

  logic [0:0] rs_sel [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] rs_dat [4] = '{2'd0, 2'd1, 2'd0, 2'd1};

  initial begin
    reset = 1'b1;
    d2_in_valid = 1'b1; d2_in_sel = 1'b0; d2_in_data = 2'd3; d2_out_ready = 2'b11;
    d3_in_valid = 1'b1; d3_in_sel = 2'd0; d3_in_data = 8'h5A; d3_out_ready = 3'b111;

    // Reset held 3 cycles with valid high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rdy2", d2_in_ready, 0);
      check("rst_rdy3", d3_in_ready, 0);
      check("rst_vld2", d2_out_valid, 0);
      check("rst_vld3", d3_out_valid, 0);
      check("rst_dat3", d3_out_data, 0);
      check("rst_err3", d3_err, 0);
    end
    cyc(); reset = 1'b0; d2_in_valid = 1'b0;
    @(negedge clk);
    check("first_rdy", d3_in_ready, 1);
    q3[0].push_back(8'h5A);
    cyc(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("first_vld", d3_out_valid, 3'b001);
    check("first_dat", d3_out_data[7:0], 8'h5A);
    cyc();

    // Routing sweep on the 2-channel instance, one beat per cycle
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        d2_in_valid = 1'b1; d2_in_sel = rs_sel[i]; d2_in_data = rs_dat[i];
      end else d2_in_valid = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        check("rs_rdy", d2_in_ready, 1);
        q2[rs_sel[i]].push_back(rs_dat[i]);
      end
      if (i > 0) begin
        check("rs_vld", d2_out_valid, (rs_sel[i-1] == 1'b1) ? 2'b10 : 2'b01);
        check("rs_dat", (rs_sel[i-1] == 1'b1) ? d2_out_data[3:2] : d2_out_data[1:0], rs_dat[i-1]);
      end
      cyc();
    end

    // Back-pressure on ch1
    d3_out_ready = 3'b101;
    d3_in_valid = 1'b1; d3_in_sel = 2'd1; d3_in_data = 8'hA5;
    @(negedge clk);
    check("bp_rdy_a5", d3_in_ready, 1);
    q3[1].push_back(8'hA5);
    cyc(); d3_in_data = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall_rdy", d3_in_ready, 0);
      check("bp_hold_vld", d3_out_valid, 3'b010);
      check("bp_hold_dat", d3_out_data[15:8], 8'hA5);
      cyc();
    end
    d3_out_ready = 3'b111;
    @(negedge clk);
    check("bp_rel_rdy", d3_in_ready, 1);
    q3[1].push_back(8'h3C);
    cyc(); d3_in_sel = 2'd2; d3_in_data = 8'h11;
    @(negedge clk);
    check("bp_3c_vld", d3_out_valid, 3'b010);
    check("bp_3c_dat", d3_out_data[15:8], 8'h3C);
    check("bp_11_rdy", d3_in_ready, 1);
    q3[2].push_back(8'h11);
    cyc(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("bp_11_vld", d3_out_valid, 3'b100);
    check("bp_11_dat", d3_out_data[23:16], 8'h11);
    cyc();

    // Drain + fill of ch0 in the same cycle
    d3_in_valid = 1'b1; d3_in_sel = 2'd0; d3_in_data = 8'h01;
    @(negedge clk);
    q3[0].push_back(8'h01);
    cyc(); d3_in_data = 8'h02;
    @(negedge clk);
    check("df_rdy", d3_in_ready, 1);
    check("df_dat01", d3_out_data[7:0], 8'h01);
    q3[0].push_back(8'h02);
    cyc(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("df_vld", d3_out_valid, 3'b001);
    check("df_dat02", d3_out_data[7:0], 8'h02);
    cyc();
    @(negedge clk);
    check("df_empty", d3_out_valid, 3'b000);
    cyc();

    // Out-of-range select
    d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_in_data = 8'hFF;
    @(negedge clk);
    check("bad_rdy", d3_in_ready, 1);
    check("bad_err_pre", d3_err, 0);
    cyc(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("bad_err", d3_err, 1);
    check("bad_vld", d3_out_valid, 3'b000);
    cyc();
    @(negedge clk);
    check("bad_err_post", d3_err, 0);
    cyc();

`ifdef DEMUX_CNT_EN
    // Counter wrap with CNT_W=2
    reset = 1'b1; cyc(); reset = 1'b0;
    @(negedge clk);
    check("cnt_clr", d3_cnt, 0);
    d3_in_valid = 1'b1; d3_in_sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      d3_in_data = 8'(8'h20 + i);
      @(negedge clk);
      check("cnt_rdy", d3_in_ready, 1);
      q3[0].push_back(8'(8'h20 + i));
      cyc();
    end
    d3_in_valid = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    check("cnt_wrap", d3_cnt, 6'h01);
    cyc();
`endif

    // Mid-operation reset discards a held beat
    d3_out_ready = 3'b101;
    d3_in_valid = 1'b1; d3_in_sel = 2'd1; d3_in_data = 8'h77;
    @(negedge clk);
    check("mr_rdy", d3_in_ready, 1);
    q3[1].push_back(8'h77);
    cyc(); d3_in_valid = 1'b0;
    @(negedge clk);
    check("mr_full", d3_out_valid, 3'b010);
    cyc(); reset = 1'b1; clear_q();
    @(negedge clk);
    check("mr_rdy_rst", d3_in_ready, 0);
    cyc();
    @(negedge clk);
    check("mr_vld3", d3_out_valid, 3'b000);
    check("mr_dat3", d3_out_data, 0);
    check("mr_vld2", d2_out_valid, 2'b00);
`ifdef DEMUX_CNT_EN
    check("mr_cnt3", d3_cnt, 0);
    check("mr_cnt2", d2_cnt, 0);
`endif
    cyc(); reset = 1'b0; d3_out_ready = 3'b111;
    cyc(); cyc();

    @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("sb2_left_ch%0d", k), q2[k].size(), 0);
    for (int k = 0; k < 3; k++) check($sformatf("sb3_left_ch%0d", k), q3[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
